// File: rtl/multicycle_decoder_if.sv
// Instruction-field inputs and control outputs of the multicycle ARMv4 main decoder.
// master = the decoder (drives controls); slave = instruction register / datapath side.
interface multicycle_decoder_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       IRWrite;
  logic       NextPC;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic [1:0] ALUControl;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;

  modport master (
    input  Op, Funct, Rd,
    output IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc,
           ALUControl, FlagW, PCS, RegW, MemW
  );

  modport slave (
    output Op, Funct, Rd,
    input  IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc,
           ALUControl, FlagW, PCS, RegW, MemW
  );
endinterface

// File: rtl/multicycle_decoder.sv
// Moore control FSM for the multicycle ARMv4 datapath: 2-5 cycles per instruction, state-driven
// controls registered with the state; no backpressure, instruction fields must hold from DECODE on.
module multicycle_decoder (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_decoder_if.master  bus
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH
  } state_t;

  typedef struct packed {
    logic       irwrite;
    logic       nextpc;
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       aluop;
    logic       branch;
    logic       regw;
    logic       memw;
  } ctrl_t;

  state_t     state_q, state_d;
  ctrl_t      ctrl_q;
  logic [3:0] cmd;
  logic       dp_writes;
  logic [1:0] alu_ctrl;
  logic [1:0] flag_w;

  assign cmd = bus.Funct[4:1];

  // Only ADD/SUB/AND/ORR write back; CMP and unsupported commands leave the register file alone.
  assign dp_writes = (cmd == 4'b0100) || (cmd == 4'b0010) ||
                     (cmd == 4'b0000) || (cmd == 4'b1100);

  function automatic ctrl_t decode_state(state_t s, logic wb_regw);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.irwrite   = 1'b1;
        c.nextpc    = 1'b1;
        c.alusrca   = 1'b1;
        c.alusrcb   = 2'b10;
        c.resultsrc = 2'b10;
      end
      DECODE: begin
        c.alusrca   = 1'b1;
        c.alusrcb   = 2'b10;
        c.resultsrc = 2'b10;
      end
      MEMADR:   c.alusrcb = 2'b01;
      MEMREAD:  c.adrsrc  = 1'b1;
      MEMWB: begin
        c.resultsrc = 2'b01;
        c.regw      = 1'b1;
      end
      MEMWRITE: begin
        c.adrsrc = 1'b1;
        c.memw   = 1'b1;
      end
      EXECUTER: c.aluop = 1'b1;
      EXECUTEI: begin
        c.alusrcb = 2'b01;
        c.aluop   = 1'b1;
      end
      ALUWB:    c.regw = wb_regw;
      BRANCH: begin
        c.alusrcb   = 2'b01;
        c.resultsrc = 2'b10;
        c.branch    = 1'b1;
      end
      default:  c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (bus.Op)
          2'b01:   state_d = MEMADR;
          2'b00:   state_d = bus.Funct[5] ? EXECUTEI : EXECUTER;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = bus.Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = MEMWB;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      default:  state_d = FETCH;
    endcase
  end

  // Controls are decoded from the next state so they are registered alongside it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      ctrl_q  <= decode_state(FETCH, 1'b0);
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode_state(state_d, dp_writes);
    end
  end

  always_comb begin
    alu_ctrl = 2'b00;
    flag_w   = 2'b00;
    if (ctrl_q.aluop) begin
      case (cmd)
        4'b0100: begin alu_ctrl = 2'b00; flag_w = {bus.Funct[0], bus.Funct[0]}; end
        4'b0010: begin alu_ctrl = 2'b01; flag_w = {bus.Funct[0], bus.Funct[0]}; end
        4'b0000: begin alu_ctrl = 2'b10; flag_w = {bus.Funct[0], 1'b0}; end
        4'b1100: begin alu_ctrl = 2'b11; flag_w = {bus.Funct[0], 1'b0}; end
        4'b1010: begin alu_ctrl = 2'b01; flag_w = 2'b11; end
        default: begin alu_ctrl = 2'b00; flag_w = 2'b00; end
      endcase
    end
  end

  assign bus.IRWrite    = ctrl_q.irwrite;
  assign bus.NextPC     = ctrl_q.nextpc;
  assign bus.AdrSrc     = ctrl_q.adrsrc;
  assign bus.ALUSrcA    = ctrl_q.alusrca;
  assign bus.ALUSrcB    = ctrl_q.alusrcb;
  assign bus.ResultSrc  = ctrl_q.resultsrc;
  assign bus.RegW       = ctrl_q.regw;
  assign bus.MemW       = ctrl_q.memw;
  assign bus.ALUControl = alu_ctrl;
  assign bus.FlagW      = flag_w;
  assign bus.PCS        = ((bus.Rd == 4'hF) & ctrl_q.regw) | ctrl_q.branch;
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};

endmodule

// File: tb/tb_multicycle_decoder.sv
// Randomized and directed self-checking bench for multicycle_decoder against a per-cycle
// expectation model built from the instruction class and cycle index.
module tb_multicycle_decoder;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  multicycle_decoder_if bus ();

  multicycle_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Vector layout: IRWrite NextPC AdrSrc ALUSrcA ALUSrcB[2] ResultSrc[2] ALUControl[2] FlagW[2] RegW MemW PCS
  function automatic logic [14:0] observed_vec();
    return {bus.IRWrite, bus.NextPC, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
            bus.ALUControl, bus.FlagW, bus.RegW, bus.MemW, bus.PCS};
  endfunction

  function automatic int n_cycles(input logic [1:0] op, input logic [5:0] funct);
    case (op)
      2'b01:   return funct[0] ? 5 : 4;
      2'b00:   return 4;
      2'b10:   return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [14:0] expected_vec(input logic [1:0] op, input logic [5:0] funct,
                                                input logic [3:0] rd, input int k);
    logic irw = 0, npc = 0, adr = 0, asa = 0, regw = 0, memw = 0, pcs = 0;
    logic [1:0] asb = 0, rs = 0, aluc = 0, fw = 0;
    logic [3:0] cmd = funct[4:1];
    logic       s = funct[0];
    if (k == 0) begin
      irw = 1; npc = 1; asa = 1; asb = 2'b10; rs = 2'b10;
    end else if (k == 1) begin
      asa = 1; asb = 2'b10; rs = 2'b10;
    end else if (op == 2'b01) begin
      if (k == 2) asb = 2'b01;
      else if (k == 3) begin adr = 1; memw = ~funct[0]; end
      else begin rs = 2'b01; regw = 1; pcs = (rd == 4'd15); end
    end else if (op == 2'b00) begin
      if (k == 2) begin
        asb = funct[5] ? 2'b01 : 2'b00;
        case (cmd)
          4'd4:    begin aluc = 2'b00; fw = {s, s}; end
          4'd2:    begin aluc = 2'b01; fw = {s, s}; end
          4'd0:    begin aluc = 2'b10; fw = {s, 1'b0}; end
          4'd12:   begin aluc = 2'b11; fw = {s, 1'b0}; end
          4'd10:   begin aluc = 2'b01; fw = 2'b11; end
          default: begin aluc = 2'b00; fw = 2'b00; end
        endcase
      end else begin
        regw = (cmd == 4'd4) || (cmd == 4'd2) || (cmd == 4'd0) || (cmd == 4'd12);
        pcs  = regw && (rd == 4'd15);
      end
    end else if (op == 2'b10) begin
      asb = 2'b01; rs = 2'b10; pcs = 1;
    end
    return {irw, npc, adr, asa, asb, rs, aluc, fw, regw, memw, pcs};
  endfunction

  // Called mid-cycle (just after a falling edge); leaves the bench mid-cycle of cycle last_k.
  task automatic run_instr(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                           input int first_k, input int last_k);
    for (int k = first_k; k <= last_k; k++) begin
      if (k == 0) begin
        bus.Op = op; bus.Funct = funct; bus.Rd = rd;
      end
      #1;
      check_val($sformatf("ctrl op=%0d f=%06b rd=%0d k=%0d", op, funct, rd, k),
                {17'd0, observed_vec()}, {17'd0, expected_vec(op, funct, rd, k)});
      check_val($sformatf("immsrc/regsrc op=%0d k=%0d", op, k),
                {28'd0, bus.ImmSrc, bus.RegSrc},
                {28'd0, op, (op == 2'b01), (op == 2'b10)});
      if (k != last_k) @(negedge clk);
    end
  endtask

  task automatic do_instr(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd);
    run_instr(op, funct, rd, 0, n_cycles(op, funct) - 1);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    bus.Op = 2'b00; bus.Funct = 6'd0; bus.Rd = 4'd0;
    #1;
    check_val("reset state", {17'd0, observed_vec()}, {17'd0, expected_vec(2'b00, 6'd0, 4'd0, 0)});
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // LDR interrupted by reset in MEMREAD; must resume cleanly at FETCH with no write strobe.
    run_instr(2'b01, 6'b011001, 4'd3, 0, 3);
    reset = 1'b1;
    #1;
    check_val("async reset in MEMREAD", {17'd0, observed_vec()},
              {17'd0, expected_vec(2'b01, 6'b011001, 4'd3, 0)});
    @(posedge clk); #1;
    check_val("reset held over edge", {17'd0, observed_vec()},
              {17'd0, expected_vec(2'b01, 6'b011001, 4'd3, 0)});
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_instr(2'b01, 6'b011001, 4'd3, 1, 4);
    @(negedge clk);

    do_instr(2'b01, 6'b011001, 4'd3);   // LDR
    do_instr(2'b01, 6'b011000, 4'd5);   // STR
    do_instr(2'b00, 6'b001001, 4'd2);   // ADDS reg
    do_instr(2'b00, 6'b100101, 4'd4);   // SUBS imm
    do_instr(2'b00, 6'b010101, 4'd1);   // CMP
    do_instr(2'b00, 6'b000001, 4'd6);   // ANDS
    do_instr(2'b00, 6'b011000, 4'd7);   // ORR, S=0
    do_instr(2'b10, 6'b000000, 4'd0);   // B
    do_instr(2'b00, 6'b001000, 4'd15);  // ADD to PC
    do_instr(2'b01, 6'b011001, 4'd15);  // LDR to PC
    do_instr(2'b11, 6'b111111, 4'd15);  // undefined, no-op

    for (int i = 0; i < 300; i++) begin
      logic [1:0] op;
      logic [5:0] funct;
      logic [3:0] rd;
      op    = 2'($urandom_range(0, 3));
      funct = 6'($urandom);
      rd    = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      do_instr(op, funct, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
